ram_ctrl: RTL and testbench

RAM_CTRL -- requirements
Module: ram_ctrl

---
 rtl/ram_pkg.sv | 15 +
 rtl/ram_array.sv | 37 +++
 rtl/ram_ctrl.sv | 112 +++++++++++
 tb/tb_ram_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared FSM state encoding and operation constants for the RAM controller.
package ram_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_e;

endpackage

// File: rtl/ram_array.sv
// Single-port storage: synchronous full-word write, synchronous registered read.
// Contents are never reset; only the read-data register is.
module ram_array #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 256
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Read register holds its value until the next read completes.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ram_ctrl.sv
// Request sequencer for a single-port RAM: capture in IDLE, access in ACCESS,
// one-cycle READY in RESP. Illegal RD+WR requests pulse ERR from IDLE.
module ram_ctrl
    import ram_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 256
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic              iRAM_CE,
    input  logic              iRAM_RD,
    input  logic              iRAM_WR,
    input  logic [ADDR_W-1:0] iRAM_ADDR,
    input  logic [DATA_W-1:0] iRAM_DATA_WR,
    output logic [DATA_W-1:0] oRAM_DATA_RD,
    output logic              oRAM_READY,
    output logic              oRAM_BUSY,
    output logic              oRAM_ERR
);

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic              mem_we_c;
    logic              mem_re_c;

    // Next-state and registered-output decode.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        ready_d  = 1'b0;
        busy_d   = 1'b0;
        err_d    = 1'b0;
        mem_we_c = 1'b0;
        mem_re_c = 1'b0;

        case (state_q)
            IDLE: begin
                if (iRAM_CE && (iRAM_RD ^ iRAM_WR)) begin
                    op_d    = iRAM_WR ? OP_WR : OP_RD;
                    addr_d  = iRAM_ADDR;
                    wdata_d = iRAM_DATA_WR;
                    state_d = ACCESS;
                    busy_d  = 1'b1;
                end else if (iRAM_CE && iRAM_RD && iRAM_WR) begin
                    err_d = 1'b1;
                end
            end
            ACCESS: begin
                mem_we_c = (op_q == OP_WR);
                mem_re_c = (op_q == OP_RD);
                state_d  = RESP;
                ready_d  = 1'b1;
                busy_d   = 1'b1;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            state_q <= IDLE;
            op_q    <= OP_RD;
            addr_q  <= '0;
            wdata_q <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    // Reset at the access edge must abort a pending write.
    ram_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk_i   (iCLK),
        .rst_n_i (iRST_N),
        .we_i    (mem_we_c && iRST_N),
        .re_i    (mem_re_c),
        .addr_i  (addr_q),
        .wdata_i (wdata_q),
        .rdata_o (oRAM_DATA_RD)
    );

    assign oRAM_READY = ready_q;
    assign oRAM_BUSY  = busy_q;
    assign oRAM_ERR   = err_q;

endmodule

// File: tb/tb_ram_ctrl.sv
// Self-checking bench for ram_ctrl: vector table of whole transactions with a
// read-data scoreboard, plus hand-written busy-ignore and mid-access reset cases.
module tb_ram_ctrl;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 256;
    localparam int K_NONE = 0;
    localparam int K_RDY  = 1;
    localparam int K_ERR  = 2;
    localparam int NVEC   = 13;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              ce = 1'b0;
    logic              rd = 1'b0;
    logic              wr = 1'b0;
    logic [ADDR_W-1:0] addr = '0;
    logic [DATA_W-1:0] wdata = '0;
    logic [DATA_W-1:0] rdata;
    logic              ready;
    logic              busy;
    logic              err;

    always #5 clk = ~clk;

    ram_ctrl #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .iCLK         (clk),
        .iRST_N       (rst_n),
        .iRAM_CE      (ce),
        .iRAM_RD      (rd),
        .iRAM_WR      (wr),
        .iRAM_ADDR    (addr),
        .iRAM_DATA_WR (wdata),
        .oRAM_DATA_RD (rdata),
        .oRAM_READY   (ready),
        .oRAM_BUSY    (busy),
        .oRAM_ERR     (err)
    );

    typedef struct {
        logic              ce;
        logic              rd;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        int                kind;
        logic [DATA_W-1:0] exp_rd;
        string             name;
    } vec_t;

    int                n_tests = 0;
    int                n_fail  = 0;
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] last_rd = '0;
    vec_t              vecs[NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic c, input logic r, input logic w,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        ce = c; rd = r; wr = w; addr = a; wdata = d;
    endtask

    task automatic idle_inputs();
        ce = 1'b0; rd = 1'b0; wr = 1'b0;
    endtask

    task automatic run_txn(input vec_t v);
        int   cyc;
        logic seen;
        @(negedge clk);
        drive(v.ce, v.rd, v.wr, v.addr, v.data);
        if (v.kind == K_RDY && v.rd && !v.wr) exp_q.push_back(v.exp_rd);
        if (v.kind == K_NONE) begin
            seen = 1'b0;
            repeat (3) begin
                @(negedge clk);
                seen = seen | ready | busy | err;
            end
            check({v.name, " no-response"}, 32'(seen), 32'd0);
            idle_inputs();
        end else if (v.kind == K_ERR) begin
            @(negedge clk);
            check({v.name, " err/busy/ready"}, 32'({err, busy, ready}), 32'b100);
            idle_inputs();
            @(negedge clk);
            check({v.name, " err one cycle"}, 32'({err, busy}), 32'd0);
        end else begin
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
            end while (!ready && cyc < 8);
            check({v.name, " ready latency"}, 32'(cyc), 32'd2);
            check({v.name, " busy at ready"}, 32'(busy), 32'd1);
            idle_inputs();
            if (v.rd && !v.wr) begin
                if (exp_q.size() > 0) begin
                    last_rd = exp_q.pop_front();
                    check({v.name, " read data"}, rdata, last_rd);
                end
            end else begin
                check({v.name, " rdata held"}, rdata, last_rd);
            end
            @(negedge clk);
            check({v.name, " ready/busy drop"}, 32'({ready, busy}), 32'd0);
        end
    endtask

    initial begin
        int   cyc;
        logic seen;
        vec_t v;

        vecs[0]  = '{1'b1, 1'b0, 1'b1, 8'h10, 32'hDEADBEEF, K_RDY,  32'h0,        "wr 0x10"};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 8'h10, 32'h0,        K_RDY,  32'hDEADBEEF, "rd 0x10"};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 8'h05, 32'hCAFEF00D, K_RDY,  32'h0,        "wr 0x05"};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 8'h05, 32'h0BAD0BAD, K_ERR,  32'h0,        "rd+wr 0x05"};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 8'h05, 32'h0,        K_RDY,  32'hCAFEF00D, "rd 0x05"};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 8'hFF, 32'hA5A5A5A5, K_RDY,  32'h0,        "wr 0xFF"};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 8'hFF, 32'h0,        K_RDY,  32'hA5A5A5A5, "rd 0xFF"};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 8'h00, 32'h5A5A5A5A, K_RDY,  32'h0,        "wr 0x00"};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 8'h00, 32'h0,        K_RDY,  32'h5A5A5A5A, "rd 0x00"};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 8'hFF, 32'h0,        K_RDY,  32'hA5A5A5A5, "re-rd 0xFF"};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 8'h10, 32'h77777777, K_NONE, 32'h0,        "ce only"};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 8'h10, 32'h0,        K_NONE, 32'h0,        "no ce"};
        vecs[12] = '{1'b1, 1'b0, 1'b1, 8'h30, 32'h0BADCAFE, K_RDY,  32'h0,        "wr 0x30"};

        // Reset state.
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset rdata", rdata, 32'h0);
        check("reset ready/busy/err", 32'({ready, busy, err}), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) run_txn(vecs[i]);

        // Request changed while busy must be ignored.
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, 8'h20, 32'h22222222);
        @(negedge clk);
        check("busy-ignore accepted", 32'({busy, ready}), 32'b10);
        wdata = 32'h11111111;
        @(negedge clk);
        check("busy-ignore ready", 32'(ready), 32'd1);
        idle_inputs();
        @(negedge clk);
        check("busy-ignore drop", 32'({ready, busy}), 32'd0);
        v = '{1'b1, 1'b1, 1'b0, 8'h20, 32'h0, K_RDY, 32'h22222222, "rd 0x20"};
        run_txn(v);

        // Reset sampled at the access edge aborts the write.
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, 8'h30, 32'h12345678);
        @(negedge clk);
        check("rst-abort accepted", 32'(busy), 32'd1);
        rst_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        check("rst-abort outputs", 32'({ready, busy, err}), 32'd0);
        check("rst-abort rdata", rdata, 32'h0);
        last_rd = '0;
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            seen = seen | ready;
        end
        check("rst-abort no ready", 32'(seen), 32'd0);
        v = '{1'b1, 1'b1, 1'b0, 8'h30, 32'h0, K_RDY, 32'h0BADCAFE, "rd 0x30"};
        run_txn(v);

        check("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
